instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the PC value loaded at reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: the number of consecutive mem_req cycles without mem_ready before a fetch aborts (used only when FETCH_TIMEOUT_EN is defined).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk  in  1  The single clock; all state updates on posedge.
REQ-005 rst_n  in  1  Asynchronous, active-low reset.
REQ-006 start  in  1  One-cycle fetch request from the control FSM.
REQ-007 pc_write  in  1  Load pc_next into the PC.
REQ-008 pc_next  in  32  New PC value for a branch or jump.
REQ-009 mem_rdata  in  32  Instruction word returned by memory.
REQ-010 mem_ready  in  1  Memory data valid; sampled only while mem_req=1.
REQ-011 mem_req  out  1  Memory read request.
REQ-012 mem_addr  out  32  Read address; equals pc while mem_req=1.
REQ-013 pc  out  32  Current PC.
REQ-014 ir_data  out  32  Fetched word; feeds the downstream instruction register idat.
REQ-015 ir_write  out  1  One-cycle strobe; drives the downstream instruction register RegWrite.
REQ-016 busy  out  1  High whenever the state is not IDLE.
REQ-017 fetch_err  out  1  One-cycle pulse that flags a timed-out fetch.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE. Transitions:
  - IDLE -> REQ on start.
  - REQ -> WAIT.
  - WAIT -> DONE on mem_ready.
  - DONE -> IDLE unconditionally.
REQ-019 mem_req SHALL be 1 in REQ and WAIT and 0 otherwise; mem_ready=1 in REQ SHALL go directly to DONE.
REQ-020 When mem_ready=1 with mem_req=1, the block SHALL register mem_rdata into ir_data; ir_data holds its value until the next capture.
REQ-021 ir_write SHALL be 1 only in DONE, for exactly one cycle per successful fetch.
REQ-022 In DONE, pc SHALL load pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-023 pc_write SHALL be accepted only in IDLE; pc loads {pc_next[31:2],2'b00}.
REQ-024 pc_write and start in the same IDLE cycle: the PC SHALL load first, and the fetch SHALL use the new PC.
REQ-025 start or pc_write received while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 Latency from start (cycle 0) with mem_ready in cycle 1: ir_write and ir_data valid in cycle 2; the incremented pc visible in cycle 3.

Reset
REQ-027 While rst_n=0, the block SHALL be in this reset state:
  - state = IDLE, pc = RESET_PC, ir_data = 0.
  - mem_req, ir_write, busy and fetch_err = 0.
  - internal counter = 0.
REQ-028 Reset assertion mid-fetch SHALL drop mem_req immediately (asynchronously), with no ir_write pulse.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined, the fetch SHALL time out as follows:
  - A counter counts consecutive mem_req cycles without mem_ready.
  - On reaching TIMEOUT_CYCLES, the FSM returns to IDLE and fetch_err pulses for 1 cycle.
  - There is no ir_write pulse, and pc is unchanged.
  - The counter clears at every fetch start.
REQ-030 Without FETCH_TIMEOUT_EN, the block SHALL wait indefinitely for mem_ready, fetch_err SHALL be tied to 0, and no counter logic SHALL be present.

Structure
REQ-031 The shared package cpu_pkg SHALL hold the fetch state enum typedef, the RESET_PC default and the PC_INCR=4 constant.
REQ-032 The timeout counter SHALL be a sub-module, fetch_timer, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-033 Reset, then start with mem_ready in cycle 1 and mem_rdata=32'h2008_0005 -> ir_write=1 in cycle 2 with ir_data=32'h2008_0005, then pc=4.
REQ-034 pc_write=1 with pc_next=32'h0000_0043 and start in the same cycle -> mem_addr=32'h0000_0040, and after the fetch pc=32'h0000_0044.
REQ-035 pc=32'hFFFF_FFFC, successful fetch -> pc=0.
REQ-036 mem_ready delayed 5 cycles, with start and pc_write pulsed during WAIT -> exactly one ir_write, and pc_next is ignored.
REQ-037 With FETCH_TIMEOUT_EN and mem_ready never asserted -> after 16 mem_req cycles, fetch_err pulses once, ir_write stays 0 and pc is unchanged.
REQ-038 rst_n driven low in WAIT -> mem_req=0 without waiting for a clock edge, pc=RESET_PC, and no ir_write.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, reset PC default and PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Branch/jump targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive stalled memory-request cycles and flags expiry on the
// cycle that would reach TIMEOUT_CYCLES. Only built with FETCH_TIMEOUT_EN.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Any cycle that is not a stalled request breaks the run of consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !count) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = count && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/REQ/WAIT/DONE handshake with memory, PC update
// and instruction-register strobe. Optional fetch timeout under FETCH_TIMEOUT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] ir_data,
  output logic        ir_write,
  output logic        busy,
  output logic        fetch_err
);

  fetch_state_t state;
  logic         timeout;

`ifdef FETCH_TIMEOUT_EN
  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state == IDLE) && start),
    .count  (mem_req && !mem_ready),
    .expired(timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  // The PC only changes outside REQ/WAIT, so it is a stable fetch address.
  assign mem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir_data   <= '0;
      mem_req   <= 1'b0;
      ir_write  <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      ir_write  <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_write) begin
            pc <= word_align(pc_next);
          end
          if (start) begin
            state   <= REQ;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ, WAIT: begin
          if (mem_ready) begin
            state    <= DONE;
            ir_data  <= mem_rdata;
            mem_req  <= 1'b0;
            ir_write <= 1'b1;
          end else if (timeout) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          pc    <= pc + PC_INCR;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch; timeout scenario built with FETCH_TIMEOUT_EN.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pc_write;
  logic [31:0] pc_next;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] pc;
  logic [31:0] ir_data;
  logic        ir_write;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pc_write (pc_write),
    .pc_next  (pc_next),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .pc       (pc),
    .ir_data  (ir_data),
    .ir_write (ir_write),
    .busy     (busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_cnt;
    int req_cnt;
    int err_cnt;
    rst_n = 1'b0; start = 1'b0; pc_write = 1'b0; pc_next = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #23;
    check("rst_pc",        pc,        32'h0);
    check("rst_ir_data",   ir_data,   32'h0);
    check("rst_mem_req",   32'(mem_req),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_ir_write",  32'(ir_write),  32'h0);
    check("rst_fetch_err", 32'(fetch_err), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic fetch with ready in the first request cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_mem_req",  32'(mem_req), 32'h1);
    check("t1_busy",     32'(busy),    32'h1);
    check("t1_mem_addr", mem_addr,     32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    check("t1_ir_write", 32'(ir_write), 32'h1);
    check("t1_ir_data",  ir_data,       32'h2008_0005);
    check("t1_pc_hold",  pc,            32'h0);
    check("t1_req_drop", 32'(mem_req),  32'h0);
    tick();
    check("t1_pc_inc",    pc,            32'h4);
    check("t1_ir_write0", 32'(ir_write), 32'h0);
    check("t1_busy0",     32'(busy),     32'h0);
    check("t1_ir_hold",   ir_data,       32'h2008_0005);

    // pc_write and start together: aligned new PC is the fetch address
    pc_write = 1'b1; pc_next = 32'h0000_0043; start = 1'b1;
    tick();
    pc_write = 1'b0; start = 1'b0;
    check("t2_mem_addr", mem_addr,     32'h0000_0040);
    check("t2_mem_req",  32'(mem_req), 32'h1);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    check("t2_ir_data", ir_data, 32'h1234_5678);
    tick();
    check("t2_pc", pc, 32'h0000_0044);

    // PC wrap at the top of the address space
    pc_write = 1'b1; pc_next = 32'hFFFF_FFFC;
    tick();
    pc_write = 1'b0;
    check("t3_pc_load", pc,         32'hFFFF_FFFC);
    check("t3_busy",    32'(busy),  32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ready = 1'b0;
    tick();
    check("t3_pc_wrap", pc, 32'h0);

    // Slow memory with start/pc_write pulsed while busy
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      start     = (i == 2);
      pc_write  = (i == 2);
      pc_next   = 32'h0000_0100;
      mem_ready = (i == 5);
      mem_rdata = 32'hA5A5_0F0F;
      if (i == 4) check("t4_req_wait", 32'(mem_req), 32'h1);
      tick();
      wr_cnt += int'(ir_write);
    end
    start = 1'b0; pc_write = 1'b0; mem_ready = 1'b0;
    check("t4_ir_write_cnt", 32'(wr_cnt), 32'h1);
    check("t4_pc",           pc,          32'h4);
    check("t4_ir_data",      ir_data,     32'hA5A5_0F0F);
    check("t4_busy",         32'(busy),   32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: one error pulse after 16 request cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    req_cnt = 0; err_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      req_cnt += int'(mem_req);
      err_cnt += int'(fetch_err);
      wr_cnt  += int'(ir_write);
      tick();
    end
    check("to_req_cycles", 32'(req_cnt), 32'd16);
    check("to_err_pulses", 32'(err_cnt), 32'd1);
    check("to_ir_write",   32'(wr_cnt),  32'd0);
    check("to_pc",         pc,           32'h4);
    check("to_busy",       32'(busy),    32'h0);
`else
    req_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      err_cnt += int'(fetch_err);
      tick();
    end
    check("no_to_fetch_err", 32'(err_cnt), 32'd0);
`endif

    // Asynchronous reset in WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5_req_in_wait", 32'(mem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_req_async", 32'(mem_req), 32'h0);
    check("t5_busy_async", 32'(busy),   32'h0);
    check("t5_pc_reset",   pc,          32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    check("t5_no_ir_write", 32'(ir_write), 32'h0);
    check("t5_ir_data",     ir_data,       32'h0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_idle_after", 32'(mem_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
